// File: rtl/seq_mult8_pkg.sv
// Shared types and constants for the sequential 8x8 shift-and-add multiplier.
package mult8_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t;

  localparam int MULT_W     = 8;
  localparam int MULT_ITERS = 8;

endpackage

// File: rtl/seq_mult8_if.sv
// Request/result bundle between a client and the seq_mult8 multiply unit.
interface seq_mult8_if;
  import mult8_pkg::*;

  logic                  start;
  logic [MULT_W-1:0]     a;
  logic [MULT_W-1:0]     b;
  logic                  busy;
  logic                  done;
  logic [2*MULT_W-1:0]   product;

  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);

endinterface

// File: rtl/seq_mult8_adder8.sv
// 8-bit ripple-carry adder built from a chain of one-bit full adders.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module adder8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  logic [8:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 8; i++) begin : g_bit
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .sum (sum[i]),
      .cout(c[i+1])
    );
  end

  assign cout = c[8];
endmodule

// File: rtl/seq_mult8.sv
// Sequential 8x8 unsigned multiplier: 8 add/shift steps through adder8, registered product.
module seq_mult8
  import mult8_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  seq_mult8_if.slave   bus
);

  localparam int CNT_W = $clog2(MULT_ITERS);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MULT_ITERS - 1);

  mult_state_t           state_q;
  logic [MULT_W-1:0]     mcand_q;
  logic [2*MULT_W-1:0]   acc_q;
  logic [2*MULT_W-1:0]   acc_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [2*MULT_W-1:0]   product_q;
  logic                  busy_q;
  logic                  done_q;

  logic [MULT_W-1:0]     add_b;
  logic [MULT_W-1:0]     add_sum;
  logic                  add_cout;

  always_comb begin
    add_b = acc_q[0] ? mcand_q : '0;
  end

  adder8 u_adder8 (
    .a   (acc_q[2*MULT_W-1:MULT_W]),
    .b   (add_b),
    .cin (1'b0),
    .sum (add_sum),
    .cout(add_cout)
  );

  // Carry lands in bit 15 as the accumulator shifts right, so no overflow is lost.
  assign acc_d = {add_cout, add_sum, acc_q[MULT_W-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            mcand_q <= bus.a;
            acc_q   <= {{MULT_W{1'b0}}, bus.b};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) begin
            product_q <= acc_d;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule

// File: tb/tb_seq_mult8.sv
// Self-checking bench for seq_mult8: directed cases plus randomized back-to-back runs.
module tb_seq_mult8;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [15:0] last_prod;

  seq_mult8_if bus ();

  seq_mult8 dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete operation from IDLE, checking outputs after every edge up to the return to IDLE.
  // poke > 0 raises start (with a=b=9) for one edge after edge number poke; it must be ignored.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input int poke);
    logic [15:0] exp;
    exp = 16'(av) * 16'(bv);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = 8'($urandom);
    bus.b     = 8'($urandom);
    chk("busy_e0", 32'(bus.busy), 32'd1);
    chk("done_e0", 32'(bus.done), 32'd0);
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      chk($sformatf("busy_e%0d", k), 32'(bus.busy), (k <= 8) ? 32'd1 : 32'd0);
      chk($sformatf("done_e%0d", k), 32'(bus.done), (k == 8) ? 32'd1 : 32'd0);
      chk($sformatf("prod_e%0d", k), 32'(bus.product), (k >= 8) ? 32'(exp) : 32'(last_prod));
      if (k == poke + 1) bus.start = 1'b0;
      if (k == poke) begin
        bus.start = 1'b1;
        bus.a     = 8'd9;
        bus.b     = 8'd9;
      end
    end
    bus.start = 1'b0;
    last_prod = exp;
  endtask

  initial begin
    logic [15:0] exp;
    int          ndone;

    checks    = 0;
    failures  = 0;
    last_prod = '0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_prod", 32'(bus.product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // idle with start low: nothing happens
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy", 32'(bus.busy), 32'd0);

    run_op(8'd13, 8'd11, 0);
    chk("basic_prod", 32'(bus.product), 32'h008F);
    run_op(8'd255, 8'd255, 0);
    chk("carry_prod", 32'(bus.product), 32'hFE01);
    run_op(8'd0, 8'd200, 0);
    run_op(8'd200, 8'd0, 0);
    chk("zero_prod", 32'(bus.product), 32'h0000);

    run_op(8'd3, 8'd5, 4);
    repeat (4) @(posedge clk);
    #1;
    chk("nobusy_after_poke", 32'(bus.busy), 32'd0);
    chk("prod_held_after_poke", 32'(bus.product), 32'd15);

    // asynchronous reset in the middle of a run
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'd100;
    bus.b     = 8'd100;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_prod", 32'(bus.product), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_hold_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    last_prod = '0;
    run_op(8'd7, 8'd6, 0);
    chk("after_rst_prod", 32'(bus.product), 32'd42);

    // start held high: a new run is accepted every 10 cycles
    @(negedge clk);
    bus.a     = 8'($urandom);
    bus.b     = 8'($urandom);
    bus.start = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      chk("rnd_accept_busy", 32'(bus.busy), 32'd1);
      exp   = 16'(bus.a) * 16'(bus.b);
      bus.a = 8'($urandom);
      bus.b = 8'($urandom);
      ndone = 0;
      for (int k = 1; k <= 9; k++) begin
        @(posedge clk); #1;
        if (bus.done === 1'b1) ndone++;
        if (k == 8) begin
          chk("rnd_done_e8", 32'(bus.done), 32'd1);
          chk("rnd_prod", 32'(bus.product), 32'(exp));
        end
      end
      chk("rnd_busy_e9", 32'(bus.busy), 32'd0);
      chk("rnd_ndone", 32'(ndone), 32'd1);
    end
    bus.start = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
